calc2_port_requester: RTL

Hardware initiator for one calc2 request/response port. It accepts abstract operations from an upstream valid/ready source and allocates a free 2-bit tag. It drives the calc2 two-cycle request sequence, then matches returning out_resp/out_data/out_tag to outstanding tags and emits one completion per operation. It sits between a traffic generator or checker and one of the four calc2_top ports, replacing software driving of req*_cmd_in/data_in/tag_in.

---
 rtl/calc2_pkg.sv | 52 +++++
 rtl/calc2_tag_tracker.sv | 148 ++++++++++++++
 rtl/calc2_port_requester.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/calc2_pkg.sv
// -----------------------------------------------------------------------------
// calc2_pkg
// Shared types and constants for the calc2 port requester.
//   - cmd_e   : calc2 command codes
//   - resp_e  : calc2 response codes (NONE = no response / timeout)
//   - state_e : request-sequencer FSM states
//   - tag_t   : 2-bit transaction tag, NUM_TAGS outstanding at most
//   - lowest_set() : priority encoder returning the lowest set bit index
// -----------------------------------------------------------------------------
package calc2_pkg;

  localparam int NUM_TAGS       = 4;
  localparam int TAG_W          = 2;
  localparam int CMD_W          = 4;
  localparam int RESP_W         = 2;
  localparam int DATA_W_DEFAULT = 32;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND1 = 2'd1,
    ST_SEND2 = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify
  // the result with an OR-reduction of the same vector).
  function automatic tag_t lowest_set(input logic [NUM_TAGS-1:0] v);
    tag_t r;
    r = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (v[i]) r = tag_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/calc2_tag_tracker.sv
// -----------------------------------------------------------------------------
// calc2_tag_tracker
// Bookkeeping for outstanding calc2 tags: outstanding bitmap, the command
// issued on each tag, per-tag timeout counters, lowest-free-tag encoder and
// arbitration of the single completion port.
//
// Ports:
//   c_clk, reset          : clock, synchronous active-high reset
//   i_alloc               : a new operation is accepted this cycle
//   i_alloc_tag/_cmd      : tag being allocated and the command issued on it
//   i_resp/i_data/i_tag   : calc2 response channel (i_resp != 0 means valid)
//   o_free_avail          : at least one tag is free (registered bitmap)
//   o_free_tag            : lowest-numbered free tag
//   o_outstanding         : outstanding bitmap (also useful for debug)
//   o_cpl_*               : registered completion (one-cycle strobe)
//   o_err_unexp           : pulse, response arrived on a non-outstanding tag
//   o_err_timeout         : pulse, coincident with a timeout completion
// -----------------------------------------------------------------------------
module calc2_tag_tracker
  import calc2_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                i_alloc,
  input  tag_t                i_alloc_tag,
  input  logic [CMD_W-1:0]    i_alloc_cmd,
  input  logic [RESP_W-1:0]   i_resp,
  input  logic [DATA_W-1:0]   i_data,
  input  tag_t                i_tag,
  output logic                o_free_avail,
  output tag_t                o_free_tag,
  output logic [NUM_TAGS-1:0] o_outstanding,
  output logic                o_cpl_valid,
  output logic [RESP_W-1:0]   o_cpl_resp,
  output logic [DATA_W-1:0]   o_cpl_data,
  output tag_t                o_cpl_tag,
  output logic [CMD_W-1:0]    o_cpl_cmd,
  output logic                o_err_unexp,
  output logic                o_err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT_CYCLES);

  logic [NUM_TAGS-1:0] r_outst;
  logic [CMD_W-1:0]    r_cmd_store [NUM_TAGS];
  logic [CNT_W-1:0]    r_cnt       [NUM_TAGS];

  logic                r_cpl_valid;
  logic [RESP_W-1:0]   r_cpl_resp;
  logic [DATA_W-1:0]   r_cpl_data;
  tag_t                r_cpl_tag;
  logic [CMD_W-1:0]    r_cpl_cmd;
  logic                r_err_unexp;
  logic                r_err_timeout;

  logic [NUM_TAGS-1:0] w_sat;
  logic                w_resp_valid;
  logic                w_hit;
  logic                w_miss;
  logic                w_to_any;
  tag_t                w_to_tag;

  always_comb begin
    w_sat = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_sat[i] = r_outst[i] && (r_cnt[i] == CNT_SAT);
    end
    w_resp_valid = (i_resp != '0);
    w_hit        = w_resp_valid && r_outst[i_tag];
    w_miss       = w_resp_valid && !r_outst[i_tag];
    w_to_any     = |w_sat;
    w_to_tag     = lowest_set(w_sat);
  end

  // Allocation reads only the registered bitmap, so a tag retired this
  // cycle becomes allocatable one cycle later.
  assign o_free_avail  = |(~r_outst);
  assign o_free_tag    = lowest_set(~r_outst);
  assign o_outstanding = r_outst;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_outst       <= '0;
      r_cpl_valid   <= 1'b0;
      r_cpl_resp    <= '0;
      r_cpl_data    <= '0;
      r_cpl_tag     <= '0;
      r_cpl_cmd     <= '0;
      r_err_unexp   <= 1'b0;
      r_err_timeout <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_cmd_store[i] <= '0;
        r_cnt[i]       <= '0;
      end
    end else begin
      r_cpl_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_unexp   <= w_miss;

      // Age every outstanding tag, holding at the saturation value.
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (r_outst[i] && (r_cnt[i] != CNT_SAT)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end

      // A matched response owns the completion port; a saturated tag waits.
      // A response on a tag that is also saturated retires as a response.
      if (w_hit) begin
        r_cpl_valid      <= 1'b1;
        r_cpl_resp       <= i_resp;
        r_cpl_data       <= i_data;
        r_cpl_tag        <= i_tag;
        r_cpl_cmd        <= r_cmd_store[i_tag];
        r_outst[i_tag]   <= 1'b0;
      end else if (w_to_any) begin
        r_cpl_valid      <= 1'b1;
        r_cpl_resp       <= RESP_NONE;
        r_cpl_data       <= '0;
        r_cpl_tag        <= w_to_tag;
        r_cpl_cmd        <= r_cmd_store[w_to_tag];
        r_err_timeout    <= 1'b1;
        r_outst[w_to_tag] <= 1'b0;
      end

      // The allocated tag is free in r_outst, so it never collides with
      // the retirement above.
      if (i_alloc) begin
        r_outst[i_alloc_tag]     <= 1'b1;
        r_cnt[i_alloc_tag]       <= '0;
        r_cmd_store[i_alloc_tag] <= i_alloc_cmd;
      end
    end
  end

  assign o_cpl_valid   = r_cpl_valid;
  assign o_cpl_resp    = r_cpl_resp;
  assign o_cpl_data    = r_cpl_data;
  assign o_cpl_tag     = r_cpl_tag;
  assign o_cpl_cmd     = r_cpl_cmd;
  assign o_err_unexp   = r_err_unexp;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: rtl/calc2_port_requester.sv
// -----------------------------------------------------------------------------
// calc2_port_requester
// Initiator for one calc2 request/response port. Takes abstract operations
// from an upstream source, allocates a free tag, drives the two-cycle calc2
// request (cmd+operand1, then operand2) and turns returning responses or
// timeouts into one completion per operation.
//
// Handshake: an operation transfers on any rising edge of c_clk where
// op_valid and op_ready are both 1. op_ready does not depend on op_valid;
// the source must hold op_cmd/op_a/op_b stable while op_valid is high and
// op_ready is low.
//
// Ports:
//   c_clk, reset                      : clock, synchronous active-high reset
//   op_valid/op_ready/op_cmd/op_a/op_b: upstream operation channel
//   req_cmd_in/req_data_in/req_tag_in : to calc2 reqN_* (registered)
//   out_resp/out_data/out_tag         : from calc2 out_*N
//   cpl_valid/resp/data/tag/cmd       : completion strobe and payload
//   busy                              : any tag outstanding or FSM not idle
//   err_unexp_tag, err_timeout        : error pulses
//   o_dbg_state                       : current FSM state
//   o_dbg_outstanding                 : outstanding-tag bitmap
// -----------------------------------------------------------------------------
module calc2_port_requester
  import calc2_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [CMD_W-1:0]    op_cmd,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic [CMD_W-1:0]    req_cmd_in,
  output logic [DATA_W-1:0]   req_data_in,
  output logic [TAG_W-1:0]    req_tag_in,
  input  logic [RESP_W-1:0]   out_resp,
  input  logic [DATA_W-1:0]   out_data,
  input  logic [TAG_W-1:0]    out_tag,
  output logic                cpl_valid,
  output logic [RESP_W-1:0]   cpl_resp,
  output logic [DATA_W-1:0]   cpl_data,
  output logic [TAG_W-1:0]    cpl_tag,
  output logic [CMD_W-1:0]    cpl_cmd,
  output logic                busy,
  output logic                err_unexp_tag,
  output logic                err_timeout,
  output state_e              o_dbg_state,
  output logic [NUM_TAGS-1:0] o_dbg_outstanding
);

  state_e              r_state;
  logic [CMD_W-1:0]    r_req_cmd;
  logic [DATA_W-1:0]   r_req_data;
  tag_t                r_req_tag;
  logic [DATA_W-1:0]   r_op_b;
  tag_t                r_tag;

  logic                w_free_avail;
  tag_t                w_free_tag;
  logic [NUM_TAGS-1:0] w_outstanding;
  logic                w_accept;
  logic                w_can_accept_state;

  // New operations are taken only when the next cycle can start SEND1:
  // from IDLE, or from SEND2 where the port is about to be released.
  assign w_can_accept_state = (r_state == ST_IDLE) || (r_state == ST_SEND2);
  assign op_ready           = !reset && w_can_accept_state && w_free_avail;
  assign w_accept           = op_valid && op_ready;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req_cmd  <= '0;
      r_req_data <= '0;
      r_req_tag  <= '0;
      r_op_b     <= '0;
      r_tag      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SEND2: begin
          if (w_accept) begin
            r_state    <= ST_SEND1;
            r_req_cmd  <= op_cmd;
            r_req_data <= op_a;
            r_req_tag  <= w_free_tag;
            r_op_b     <= op_b;
            r_tag      <= w_free_tag;
          end else begin
            r_state    <= ST_IDLE;
            r_req_cmd  <= '0;
            r_req_data <= '0;
            r_req_tag  <= '0;
          end
        end
        ST_SEND1: begin
          // Second beat: command field is zero, operand 2 on the data bus.
          r_state    <= ST_SEND2;
          r_req_cmd  <= '0;
          r_req_data <= r_op_b;
          r_req_tag  <= r_tag;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_req_cmd  <= '0;
          r_req_data <= '0;
          r_req_tag  <= '0;
        end
      endcase
    end
  end

  calc2_tag_tracker #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tracker (
    .c_clk         (c_clk),
    .reset         (reset),
    .i_alloc       (w_accept),
    .i_alloc_tag   (w_free_tag),
    .i_alloc_cmd   (op_cmd),
    .i_resp        (out_resp),
    .i_data        (out_data),
    .i_tag         (out_tag),
    .o_free_avail  (w_free_avail),
    .o_free_tag    (w_free_tag),
    .o_outstanding (w_outstanding),
    .o_cpl_valid   (cpl_valid),
    .o_cpl_resp    (cpl_resp),
    .o_cpl_data    (cpl_data),
    .o_cpl_tag     (cpl_tag),
    .o_cpl_cmd     (cpl_cmd),
    .o_err_unexp   (err_unexp_tag),
    .o_err_timeout (err_timeout)
  );

  assign req_cmd_in        = r_req_cmd;
  assign req_data_in       = r_req_data;
  assign req_tag_in        = r_req_tag;
  assign busy              = (|w_outstanding) || (r_state != ST_IDLE);
  assign o_dbg_state       = r_state;
  assign o_dbg_outstanding = w_outstanding;

endmodule
